// File: rtl/matmul_pkg.sv
// ============================================================================
// Package    : matmul_pkg
// Description: Shared loader state encoding, header addresses and size limits.
// Revision   : 1.0
// ============================================================================
`default_nettype none

package matmul_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_HEADER = 3'd1,
    ST_DATA   = 3'd2,
    ST_KICK   = 3'd3,
    ST_WAIT   = 3'd4,
    ST_ERROR  = 3'd5
  } state_t;

  localparam int HDR_ROW_A_ADDR  = 0;
  localparam int HDR_COMMON_ADDR = 1;
  localparam int HDR_COL_B_ADDR  = 2;
  localparam int HDR_WORDS       = 3;

  localparam int ROW_A_MAX_DEF    = 16;
  localparam int COMMON_MAX_DEF   = 16;
  localparam int COLUMN_B_MAX_DEF = 16;

  // A dimension is usable when it is nonzero and no larger than its limit.
  function automatic logic dim_legal(input logic [31:0] value, input int unsigned max_val);
    return (value != 32'd0) && (value <= 32'(max_val));
  endfunction

endpackage

`default_nettype wire

// File: rtl/matrix_loader.sv
// ============================================================================
// Module     : matrix_loader
// Description: Streams a 3-word header plus A and B into memory, then kicks
//              the multiplier and waits for its done level.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module matrix_loader
  import matmul_pkg::*;
#(
  parameter int ROW_A_MAX    = ROW_A_MAX_DEF,
  parameter int COMMON_MAX   = COMMON_MAX_DEF,
  parameter int COLUMN_B_MAX = COLUMN_B_MAX_DEF,
  parameter int ADDR_W       = 10
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [31:0]       in_data,
  output logic              write_readbar,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_data,
  output logic              getting_input,
  output logic              start,
  input  logic              done,
  output logic              busy,
  output logic              err
);

  localparam int TOT_W = ADDR_W + 1;
  localparam int ROW_W = $clog2(ROW_A_MAX + 1);
  localparam int COM_W = $clog2(COMMON_MAX + 1);
  localparam int COL_W = $clog2(COLUMN_B_MAX + 1);

  state_t              state_q, state_d;
  logic [ADDR_W-1:0]   wr_ptr_q, wr_ptr_d;
  logic [TOT_W-1:0]    total_q, total_d;
  logic [ROW_W-1:0]    row_a_q, row_a_d;
  logic [COM_W-1:0]    common_q, common_d;
  logic                bad_q, bad_d;

  logic                accept;
  logic                last_word;
  logic [TOT_W-1:0]    row_a_ext, common_ext, col_b_ext;
  logic [TOT_W-1:0]    prod_a, prod_b, total_calc;

  // Reset also drops in_ready so nothing is written while it is held.
  assign in_ready = ~reset & (((state_q == ST_IDLE) & ~done) |
                              (state_q == ST_HEADER) | (state_q == ST_DATA));
  assign accept        = in_valid & in_ready;
  assign write_readbar = accept;
  assign mem_addr      = wr_ptr_q;
  assign mem_data      = in_data;
  assign getting_input = (state_q == ST_HEADER) | (state_q == ST_DATA) |
                         ((state_q == ST_IDLE) & accept);
  assign start         = (state_q == ST_KICK);
  assign busy          = (state_q != ST_IDLE) & (state_q != ST_ERROR);
  assign err           = (state_q == ST_ERROR);

  // column_B is still on in_data when the total is latched, so use it directly.
  assign row_a_ext  = TOT_W'(row_a_q);
  assign common_ext = TOT_W'(common_q);
  assign col_b_ext  = TOT_W'(in_data[COL_W-1:0]);
  assign prod_a     = row_a_ext * common_ext;
  assign prod_b     = common_ext * col_b_ext;
  assign total_calc = TOT_W'(HDR_WORDS) + prod_a + prod_b;

  assign last_word  = ({1'b0, wr_ptr_q} == (total_q - TOT_W'(1)));

  always_comb begin
    state_d  = state_q;
    wr_ptr_d = wr_ptr_q;
    total_d  = total_q;
    row_a_d  = row_a_q;
    common_d = common_q;
    bad_d    = bad_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          row_a_d  = in_data[ROW_W-1:0];
          bad_d    = ~dim_legal(in_data, ROW_A_MAX);
          wr_ptr_d = ADDR_W'(HDR_COMMON_ADDR);
          state_d  = ST_HEADER;
        end
      end
      ST_HEADER: begin
        if (accept) begin
          wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          if (wr_ptr_q == ADDR_W'(HDR_COMMON_ADDR)) begin
            common_d = in_data[COM_W-1:0];
            bad_d    = bad_q | ~dim_legal(in_data, COMMON_MAX);
          end else if (bad_q | ~dim_legal(in_data, COLUMN_B_MAX)) begin
            state_d = ST_ERROR;
          end else begin
            total_d = total_calc;
            state_d = ST_DATA;
          end
        end
      end
      ST_DATA: begin
        if (accept) begin
          if (last_word) begin
            wr_ptr_d = '0;
            state_d  = ST_KICK;
          end else begin
            wr_ptr_d = wr_ptr_q + ADDR_W'(1);
          end
        end
      end
      ST_KICK:  state_d = ST_WAIT;
      ST_WAIT: begin
        if (done) begin
          state_d = ST_IDLE;
        end
      end
      ST_ERROR: state_d = ST_ERROR;
      default:  state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= ST_IDLE;
      wr_ptr_q <= '0;
      total_q  <= '0;
      row_a_q  <= '0;
      common_q <= '0;
      bad_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_ptr_q <= wr_ptr_d;
      total_q  <= total_d;
      row_a_q  <= row_a_d;
      common_q <= common_d;
      bad_q    <= bad_d;
    end
  end

endmodule

`default_nettype wire

// File: tb/tb_matrix_loader.sv
// ============================================================================
// Module     : tb_matrix_loader
// Description: Randomised scoreboard bench for matrix_loader.
// Revision   : 1.0
// ============================================================================
`default_nettype none

module tb_matrix_loader;

  localparam int ADDR_W = 10;
  localparam int DMAX   = 16;

  logic              clk;
  logic              reset;
  logic              in_valid;
  logic              in_ready;
  logic [31:0]       in_data;
  logic              write_readbar;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_data;
  logic              getting_input;
  logic              start;
  logic              done;
  logic              busy;
  logic              err;

  matrix_loader #(
    .ROW_A_MAX   (DMAX),
    .COMMON_MAX  (DMAX),
    .COLUMN_B_MAX(DMAX),
    .ADDR_W      (ADDR_W)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .write_readbar(write_readbar),
    .mem_addr     (mem_addr),
    .mem_data     (mem_data),
    .getting_input(getting_input),
    .start        (start),
    .done         (done),
    .busy         (busy),
    .err          (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    bit          is_start;
    int          addr;
    logic [31:0] data;
  } ev_t;

  ev_t         exp_q[$];
  logic [31:0] words[$];
  int checks      = 0;
  int errors      = 0;
  int cyc         = 0;
  int last_wr_cyc = -100;
  int start_cnt   = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Monitor: every write or start pulse consumes the next expected event.
  always @(negedge clk) begin
    ev_t e;
    if (reset === 1'b0) begin
      if (write_readbar) begin
        chk("gi_during_write", 64'(getting_input), 64'd1);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_write: addr %0d data %h, expected no write", mem_addr, mem_data);
        end else begin
          e = exp_q.pop_front();
          chk("event_is_write", 64'(e.is_start), 64'd0);
          chk("write_addr", 64'(mem_addr), 64'(e.addr));
          chk("write_data", 64'(mem_data), 64'(e.data));
        end
        last_wr_cyc = cyc;
      end
      if (start) begin
        start_cnt++;
        chk("start_after_last_write", 64'(cyc), 64'(last_wr_cyc + 1));
        chk("gi_low_at_start", 64'(getting_input), 64'd0);
        if (exp_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_start: got start, expected none");
        end else begin
          e = exp_q.pop_front();
          chk("event_is_start", 64'(e.is_start), 64'd1);
        end
      end
    end
  end

  function automatic bit legal(input int d);
    return (d >= 1) && (d <= DMAX);
  endfunction

  // Reference model: header words, then r*c + c*k elements, then a start.
  task automatic build(input int r, input int c, input int k);
    bit ok;
    ok = legal(r) && legal(c) && legal(k);
    words.delete();
    words.push_back(32'(r));
    words.push_back(32'(c));
    words.push_back(32'(k));
    if (ok) begin
      repeat (r * c + c * k) words.push_back($urandom());
    end
    for (int i = 0; i < words.size(); i++) exp_q.push_back('{1'b0, i, words[i]});
    if (ok) exp_q.push_back('{1'b1, 0, 32'd0});
  endtask

  task automatic drive(input int n, input int gap_pct, output int cycles);
    int i;
    i      = 0;
    cycles = 0;
    while (i < n) begin
      @(posedge clk);
      #1;
      if ($urandom_range(99) < gap_pct) begin
        in_valid = 1'b0;
      end else begin
        in_valid = 1'b1;
        in_data  = words[i];
      end
      @(negedge clk);
      if (in_valid && in_ready) i++;
      cycles++;
      if (cycles > 20000) begin
        chk("drive_timeout", 64'(i), 64'(n));
        break;
      end
    end
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic finish_job(input int s0, input int done_len);
    int n;
    n = 0;
    while (start_cnt == s0 && n < 50) begin
      @(posedge clk);
      n++;
    end
    chk("start_seen", 64'(start_cnt), 64'(s0 + 1));
    repeat (3) @(negedge clk);
    chk("wait_busy", 64'(busy), 64'd1);
    chk("wait_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk);
    #1 done = 1'b1;
    for (int i = 0; i < done_len; i++) begin
      @(negedge clk);
      if (i > 0) begin
        chk("idle_busy", 64'(busy), 64'd0);
        chk("idle_ready_while_done", 64'(in_ready), 64'd0);
      end
      @(posedge clk);
      #1;
    end
    done = 1'b0;
    @(negedge clk);
    chk("idle_ready_after_done", 64'(in_ready), 64'd1);
    chk("single_start", 64'(start_cnt), 64'(s0 + 1));
    chk("queue_drained", 64'(exp_q.size()), 64'd0);
  endtask

  task automatic load(input int r, input int c, input int k, input int gap_pct, input int done_len);
    int s0, cyc_used;
    s0 = start_cnt;
    build(r, c, k);
    drive(words.size(), gap_pct, cyc_used);
    finish_job(s0, done_len);
  endtask

  task automatic bad_header(input int r, input int c, input int k);
    int cyc_used;
    build(r, c, k);
    drive(3, 0, cyc_used);
    @(negedge clk);
    chk("err_set", 64'(err), 64'd1);
    chk("err_in_ready", 64'(in_ready), 64'd0);
    chk("err_busy", 64'(busy), 64'd0);
    @(posedge clk);
    #1 in_valid = 1'b1;
    repeat (5) @(posedge clk);
    #1 in_valid = 1'b0;
    chk("err_queue_drained", 64'(exp_q.size()), 64'd0);
    reset = 1'b1;
    #1;
    chk("reset_clears_err", 64'(err), 64'd0);
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: simulation did not finish, expected completion");
    $fatal(1, "timeout");
  end

  initial begin
    int cyc_used;
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    done     = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_busy", 64'(busy), 64'd0);
    chk("rst_err", 64'(err), 64'd0);
    chk("rst_start", 64'(start), 64'd0);
    chk("rst_write", 64'(write_readbar), 64'd0);
    chk("rst_gi", 64'(getting_input), 64'd0);
    chk("rst_addr", 64'(mem_addr), 64'd0);
    @(posedge clk);
    #1 reset = 1'b0;

    // 2x2 * 2x2 with no gaps: every word must be taken on consecutive cycles.
    build(2, 2, 2);
    drive(words.size(), 0, cyc_used);
    chk("consecutive_accept_cycles", 64'(cyc_used), 64'd11);
    finish_job(0, 2);

    load(1, 1, 1, 30, 3);
    for (int t = 0; t < 4; t++) begin
      load($urandom_range(1, 4), $urandom_range(1, 4), $urandom_range(1, 4), 40,
           $urandom_range(2, 4));
    end
    load(16, 16, 16, 25, 5);

    bad_header(0, 4, 4);
    bad_header(17, 2, 2);

    // Reset during a load: only addresses 0..6 are ever written.
    build(2, 2, 2);
    while (exp_q.size() > 7) void'(exp_q.pop_back());
    drive(7, 0, cyc_used);
    #1;
    reset    = 1'b1;
    in_valid = 1'b1;
    #1;
    chk("midrst_write", 64'(write_readbar), 64'd0);
    chk("midrst_busy", 64'(busy), 64'd0);
    chk("midrst_gi", 64'(getting_input), 64'd0);
    chk("midrst_addr", 64'(mem_addr), 64'd0);
    chk("midrst_queue_drained", 64'(exp_q.size()), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    in_valid = 1'b0;
    reset    = 1'b0;
    load(2, 2, 2, 20, 2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/matrix_loader.md
MATRIX_LOADER -- requirements
Module: matrix_loader

Interface
REQ-001 Parameter ROW_A_MAX, default 16, largest legal row count of A.
REQ-002 Parameter COMMON_MAX, default 16, largest legal common factor (A columns / B rows).
REQ-003 Parameter COLUMN_B_MAX, default 16, largest legal column count of B.
REQ-004 Parameter ADDR_W, default 10, main-memory address width.
REQ-005 The block SHALL use one clock; reset is asynchronous and active-high (ports clk, reset).
REQ-006 clk  input  1  system clock, all state on rising edge.
REQ-007 reset  input  1  asynchronous active-high reset.
REQ-008 in_valid  input  1  source word valid.
REQ-009 in_ready  output  1  loader accepts word; transfer when in_valid&in_ready.
REQ-010 in_data  input  32  header dimension or matrix element (IEEE-754 single).
REQ-011 write_readbar  output  1  memory write strobe (1 = write).
REQ-012 mem_addr  output  ADDR_W  memory word address.
REQ-013 mem_data  output  32  memory write data.
REQ-014 getting_input  output  1  high while a load is in progress, to multiplier.
REQ-015 start  output  1  one-cycle pulse launching the multiplier.
REQ-016 done  input  1  multiplier completion level.
REQ-017 busy  output  1  high in any state other than IDLE and ERROR.
REQ-018 err  output  1  sticky illegal-header flag.

Function
REQ-019 FSM states SHALL be IDLE, HEADER, DATA, KICK, WAIT, ERROR.
REQ-020 Memory layout SHALL be: addr 0 row_A, 1 common_factor, 2 column_B, 3 onward A row-major, then B row-major, contiguous.
REQ-021 Every accepted word SHALL be written the same cycle: write_readbar = in_valid&in_ready, mem_addr = wr_ptr, mem_data = in_data (zero latency, combinational).
REQ-022 IDLE: in_ready = ~done; first accepted word goes to addr 0 and moves FSM to HEADER with wr_ptr=1.
REQ-023 HEADER: in_ready=1; captures words at addr 1 and 2; after addr 2, FSM goes to DATA, or ERROR if any dimension is 0 or exceeds its MAX.
REQ-024 On entering DATA, total = 3 + row_A*common + common*column_B SHALL be registered (ADDR_W+1 bits); 3+512=515 fits for defaults.
REQ-025 DATA: in_ready=1; wr_ptr increments per accepted word; word at wr_ptr = total-1 moves FSM to KICK.
REQ-026 Gaps in in_valid SHALL stall progress without writes; no word may be skipped or duplicated.
REQ-027 KICK: in_ready=0, start=1 for exactly one cycle, then WAIT.
REQ-028 getting_input SHALL be 1 in HEADER and DATA, and on the IDLE cycle accepting addr 0; 0 otherwise.
REQ-029 WAIT: in_ready=0; done=1 returns FSM to IDLE; IDLE holds in_ready=0 until done falls, preventing reuse of a stale level.
REQ-030 ERROR: in_ready=0, write_readbar=0, err=1; exit only by reset.
REQ-031 Header values SHALL be compared as unsigned integers on in_data[31:0].

Reset
REQ-032 Reset SHALL force IDLE, wr_ptr=0, total=0, captured dimensions 0, err=0, start=0, busy=0, getting_input=0, write_readbar=0.
REQ-033 Reset mid-load SHALL abandon the load without further writes; memory contents are not cleared.

Structure
REQ-034 State encoding, header addresses (0,1,2), and MAX defaults SHALL live in shared package matmul_pkg.
REQ-035 No sub-module; the dimension product SHALL use two small unsigned multipliers inside the block.

Verification
REQ-036 Header 2,2,2 plus 8 elements, in_valid constant -> writes to addr 0..10 in 11 consecutive cycles, start pulse the cycle after addr 10, getting_input high for those 11 cycles.
REQ-037 Header 16,16,16 plus 512 elements with random in_valid gaps -> last write at addr 514, exactly one start pulse, no duplicate addresses.
REQ-038 Header 0,4,4 -> ERROR after addr 2, err=1, in_ready=0, no further writes; reset clears err.
REQ-039 Header 17,2,2 -> ERROR; header 1,1,1 plus 2 elements -> start after addr 4.
REQ-040 Reset asserted after addr 6 of a 2,2,2 load -> all outputs reset immediately; new load restarts at addr 0.
REQ-041 done held 1 for 5 cycles in WAIT -> IDLE with in_ready=0 until done=0, then in_ready=1.
